// File: rtl/crc16_pkg.sv
// crc16_pkg: shared CRC-16 (0x1021) constants and checker state encoding
package crc16_pkg;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int CRC16_WIDTH = 16;
  typedef enum logic [2:0] {IDLE, DATA, CRC_HI, CRC_LO, REPORT} state_t;
endpackage

// File: rtl/crc16_byte_step.sv
// crc16_byte_step: one byte of MSB-first CRC-16 update, purely combinational
module crc16_byte_step
  import crc16_pkg::*;
(
  input  logic [CRC16_WIDTH-1:0] crc_in,
  input  logic [7:0]             byte_in,
  output logic [CRC16_WIDTH-1:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--)
      crc_out = {crc_out[CRC16_WIDTH-2:0], 1'b0} ^ ((crc_out[CRC16_WIDTH-1] ^ byte_in[i]) ? CRC16_POLY : '0);
  end
endmodule

// File: rtl/crc16_check.sv
// crc16_check: receive-side CRC-16 frame checker; CRC16_CHECK_STATS_EN adds err_cnt/drop_cnt
module crc16_check
  import crc16_pkg::*;
#(
  parameter int          FRAME_LEN = 4,
  parameter logic [15:0] CRC_INIT  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  output logic        in_ready,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic [15:0] calc_crc,
  output logic [15:0] rx_crc
`ifdef CRC16_CHECK_STATS_EN
  ,
  output logic [15:0] err_cnt,
  output logic [15:0] drop_cnt
`endif
);
  state_t      state;
  logic [15:0] crc, crc_nxt;
  logic [7:0]  cnt, rx_hi;
  logic        acc;
  assign in_ready   = state != REPORT;
  assign acc        = in_valid && in_ready;
  assign frame_done = state == REPORT;
  assign crc_ok     = frame_done && rx_crc == calc_crc;
  assign crc_err    = frame_done && rx_crc != calc_crc;
  // an sof byte restarts from CRC_INIT in any state, which also covers aborts
  crc16_byte_step u_step (
    .crc_in (in_sof ? CRC_INIT : crc),
    .byte_in(in_data),
    .crc_out(crc_nxt)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc      <= CRC_INIT;
      cnt      <= '0;
      rx_hi    <= '0;
      calc_crc <= '0;
      rx_crc   <= '0;
    end else if (state == REPORT) begin
      state <= IDLE;
    end else if (acc && in_sof) begin
      crc   <= crc_nxt;
      cnt   <= 8'd1;
      state <= (FRAME_LEN == 1) ? CRC_HI : DATA;
    end else if (acc) begin
      case (state)
        DATA: begin
          crc <= crc_nxt;
          cnt <= cnt + 8'd1;
          if (cnt == 8'(FRAME_LEN - 1)) state <= CRC_HI;
        end
        CRC_HI: begin
          rx_hi <= in_data;
          state <= CRC_LO;
        end
        CRC_LO: begin
          rx_crc   <= {rx_hi, in_data};
          calc_crc <= crc;
          state    <= REPORT;
        end
        default: ;
      endcase
    end
  end
`ifdef CRC16_CHECK_STATS_EN
  logic drop;
  assign drop = acc && (in_sof ? state != IDLE : state == IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (crc_err && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_crc16_check.sv
// tb_crc16_check: directed checks of crc16_check at FRAME_LEN 1, 9 and 4 (stats checked if CRC16_CHECK_STATS_EN)
module tb_crc16_check;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_sof = 0;
  logic [7:0]  in_data = 0;
  logic        r1, d1, o1, e1, r9, d9, o9, e9, r4, d4, o4, e4, rdy;
  logic [15:0] c1, x1, c9, x9, c4, x4;
`ifdef CRC16_CHECK_STATS_EN
  logic [15:0] ec1, dc1, ec9, dc9, ec4, dc4;
`endif
  int checks = 0, errors = 0, sel = 4, cyc = 0, fd4 = 0, nr4 = 0, t_last = 0, t_prev = 0;

  crc16_check #(.FRAME_LEN(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .in_ready(r1), .frame_done(d1), .crc_ok(o1), .crc_err(e1), .calc_crc(c1), .rx_crc(x1)
`ifdef CRC16_CHECK_STATS_EN
    , .err_cnt(ec1), .drop_cnt(dc1)
`endif
  );
  crc16_check #(.FRAME_LEN(9)) dut9 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .in_ready(r9), .frame_done(d9), .crc_ok(o9), .crc_err(e9), .calc_crc(c9), .rx_crc(x9)
`ifdef CRC16_CHECK_STATS_EN
    , .err_cnt(ec9), .drop_cnt(dc9)
`endif
  );
  crc16_check #(.FRAME_LEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .in_ready(r4), .frame_done(d4), .crc_ok(o4), .crc_err(e4), .calc_crc(c4), .rx_crc(x4)
`ifdef CRC16_CHECK_STATS_EN
    , .err_cnt(ec4), .drop_cnt(dc4)
`endif
  );

  always #5 clk = ~clk;
  assign rdy = (sel == 1) ? r1 : (sel == 9) ? r9 : r4;

  always @(posedge clk) begin
    cyc++;
    if (d4) begin
      fd4++;
      t_prev = t_last;
      t_last = cyc;
    end
    if (!r4) nr4++;
  end

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    fd4 = 0;
    nr4 = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int n = 0;
    in_valid = 1; in_data = d; in_sof = s;
    while (!rdy && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL send_ready byte=%h ready=%b required 1", d, rdy);
    end
    @(posedge clk); #1;
    in_valid = 0; in_sof = 0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                       input logic [7:0] h, input logic [7:0] l);
    send(a, 1); send(b, 0); send(c, 0); send(d, 0); send(h, 0); send(l, 0);
  endtask

  task automatic test_reset();
    #1;
    checks += 3;
    if ({r1, d1, o1, e1, c1, x1} !== {1'b1, 3'b0, 32'h0}) begin
      errors++; $display("FAIL reset_len1 got %b%b%b%b %h %h required 1000 0000 0000", r1, d1, o1, e1, c1, x1);
    end
    if ({r9, d9, o9, e9, c9, x9} !== {1'b1, 3'b0, 32'h0}) begin
      errors++; $display("FAIL reset_len9 got %b%b%b%b %h %h required 1000 0000 0000", r9, d9, o9, e9, c9, x9);
    end
    if ({r4, d4, o4, e4, c4, x4} !== {1'b1, 3'b0, 32'h0}) begin
      errors++; $display("FAIL reset_len4 got %b%b%b%b %h %h required 1000 0000 0000", r4, d4, o4, e4, c4, x4);
    end
  endtask

  task automatic test_len1();
    sel = 1;
    do_reset();
    send(8'h01, 1); send(8'h10, 0); send(8'h21, 0);
    checks++;
    if ({d1, o1, e1, r1, c1, x1} !== {4'b1100, 16'h1021, 16'h1021}) begin
      errors++; $display("FAIL len1_frame_a got done/ok/err/rdy=%b%b%b%b calc=%h rx=%h required 1100 1021 1021", d1, o1, e1, r1, c1, x1);
    end
    @(posedge clk); #1;
    checks++;
    if ({d1, o1, e1, r1, c1} !== {4'b0001, 16'h1021}) begin
      errors++; $display("FAIL len1_after_pulse got %b%b%b%b calc=%h required 0001 1021", d1, o1, e1, r1, c1);
    end
    send(8'hFF, 1); send(8'h1E, 0); send(8'hF0, 0);
    checks++;
    if ({d1, o1, e1, c1} !== {3'b110, 16'h1EF0}) begin
      errors++; $display("FAIL len1_frame_b got %b%b%b calc=%h required 110 1ef0", d1, o1, e1, c1);
    end
  endtask

  task automatic test_len9();
    sel = 9;
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), i == 0);
    send(8'h31, 0); send(8'hC3, 0);
    checks++;
    if ({d9, o9, e9, c9, x9} !== {3'b110, 16'h31C3, 16'h31C3}) begin
      errors++; $display("FAIL len9_good got %b%b%b calc=%h rx=%h required 110 31c3 31c3", d9, o9, e9, c9, x9);
    end
    for (int i = 0; i < 9; i++) send(8'h31 + 8'(i), i == 0);
    send(8'h31, 0); send(8'hC2, 0);
    checks++;
    if ({d9, o9, e9, c9, x9} !== {3'b101, 16'h31C3, 16'h31C2}) begin
      errors++; $display("FAIL len9_bad got %b%b%b calc=%h rx=%h required 101 31c3 31c2", d9, o9, e9, c9, x9);
    end
`ifdef CRC16_CHECK_STATS_EN
    @(posedge clk); #1;
    checks++;
    if (ec9 !== 16'd1) begin
      errors++; $display("FAIL len9_err_cnt got %0d required 1", ec9);
    end
`endif
  endtask

  task automatic test_idle_drop();
    sel = 4;
    do_reset();
    send(8'hAA, 0); send(8'h55, 0); send(8'h12, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fd4 !== 0 || r4 !== 1'b1) begin
      errors++; $display("FAIL idle_drop got pulses=%0d ready=%b required 0 1", fd4, r4);
    end
`ifdef CRC16_CHECK_STATS_EN
    checks++;
    if (dc4 !== 16'd3) begin
      errors++; $display("FAIL idle_drop_cnt got %0d required 3", dc4);
    end
`endif
    send4(8'h00, 8'h00, 8'h00, 8'h01, 8'h10, 8'h21);
    checks++;
    if ({d4, o4, e4, c4} !== {3'b110, 16'h1021}) begin
      errors++; $display("FAIL idle_then_frame got %b%b%b calc=%h required 110 1021", d4, o4, e4, c4);
    end
  endtask

  task automatic test_abort();
    do_reset();
    send(8'h12, 1); send(8'h34, 0); send(8'h56, 0);
    send4(8'h00, 8'h00, 8'h00, 8'h01, 8'h10, 8'h21);
    checks++;
    if ({d4, o4, c4} !== {2'b11, 16'h1021}) begin
      errors++; $display("FAIL abort_frame got done=%b ok=%b calc=%h required 1 1 1021", d4, o4, c4);
    end
    @(posedge clk); #1;
    checks++;
    if (fd4 !== 1) begin
      errors++; $display("FAIL abort_pulses got %0d required 1", fd4);
    end
`ifdef CRC16_CHECK_STATS_EN
    checks++;
    if (dc4 !== 16'd1) begin
      errors++; $display("FAIL abort_drop_cnt got %0d required 1", dc4);
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    send4(8'h00, 8'h00, 8'h00, 8'h01, 8'h10, 8'h21);
    checks++;
    if ({d4, o4, c4} !== {2'b11, 16'h1021}) begin
      errors++; $display("FAIL b2b_first got done=%b ok=%b calc=%h required 1 1 1021", d4, o4, c4);
    end
    send4(8'h00, 8'h00, 8'h00, 8'hFF, 8'h1E, 8'hF0);
    checks++;
    if ({d4, o4, c4} !== {2'b11, 16'h1EF0}) begin
      errors++; $display("FAIL b2b_second got done=%b ok=%b calc=%h required 1 1 1ef0", d4, o4, c4);
    end
    @(posedge clk); #1;
    checks++;
    if (fd4 !== 2 || t_last - t_prev !== 7 || nr4 !== 2) begin
      errors++; $display("FAIL b2b_timing got pulses=%0d spacing=%0d not_ready=%0d required 2 7 2", fd4, t_last - t_prev, nr4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send4(8'h00, 8'h00, 8'h00, 8'h01, 8'h10, 8'h21);
    send(8'h00, 1); send(8'h00, 0); send(8'h00, 0); send(8'hFF, 0); send(8'h1E, 0);
    rst_n = 0;
    #1;
    checks++;
    if ({r4, d4, o4, e4, c4, x4} !== {1'b1, 3'b0, 32'h0}) begin
      errors++; $display("FAIL reset_mid got %b%b%b%b %h %h required 1000 0000 0000", r4, d4, o4, e4, c4, x4);
    end
    fd4 = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (fd4 !== 0) begin
      errors++; $display("FAIL reset_mid_pulse got %0d required 0", fd4);
    end
    send4(8'h00, 8'h00, 8'h00, 8'hFF, 8'h1E, 8'hF0);
    checks++;
    if ({d4, o4, e4, c4, x4} !== {3'b110, 16'h1EF0, 16'h1EF0}) begin
      errors++; $display("FAIL reset_mid_next got %b%b%b calc=%h rx=%h required 110 1ef0 1ef0", d4, o4, e4, c4, x4);
    end
  endtask

  initial begin
    test_reset();
    test_len1();
    test_len9();
    test_idle_drop();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
